// File: rtl/alu_issue_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_pkg
//   Shared definitions for the ALU issue front end:
//     - ALU opcode encodings. The issue block passes these through and never
//       decodes them. They live here so the issue logic, the ALU and any
//       bench all use the same values.
//     - alu_cmd_t: the opcode and operand bundle stored in each FIFO entry.
//     - A saturating increment helper for the 16-bit stall counter.
// -----------------------------------------------------------------------------
package alu_issue_pkg;

  // Opcode encodings (5 bits).
  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b01000;
  localparam logic [4:0] OP_SLL   = 5'b00001;
  localparam logic [4:0] OP_SLT   = 5'b00010;
  localparam logic [4:0] OP_SLTU  = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_SEQ   = 5'b01100;
  localparam logic [4:0] OP_SRL   = 5'b00101;
  localparam logic [4:0] OP_SRA   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_AND   = 5'b00111;
  localparam logic [4:0] OP_PFIND = 5'b10000;
  localparam logic [4:0] OP_PCLR  = 5'b10001;

  localparam int OP_W   = 5;
  localparam int DATA_W = 32;

  // Opcode and operands as presented to the ALU.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == STALL_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_issue_fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
//   Generic single-clock FIFO. head_o always shows the oldest entry
//   (first-word fall-through). A push while full and a pop while empty are
//   both ignored. clr_i empties the FIFO on the next edge, in the same way
//   as rst.
//
// Ports
//   clk     in  : clock, rising edge
//   rst     in  : synchronous active-high reset
//   clr_i   in  : synchronous clear (flush)
//   push_i  in  : write din_i at the tail
//   din_i   in  : write data [WIDTH-1:0]
//   pop_i   in  : discard the head entry
//   head_o  out : oldest entry [WIDTH-1:0]. Undefined while empty_o is high.
//   full_o  out : DEPTH entries are stored
//   empty_o out : no entries are stored
// -----------------------------------------------------------------------------
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: always_comb starts every output from a default. This way no path
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;   // idle, or push and pop together
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then sample their inputs from before the edge, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset. Validity is tracked only by the
  // pointers and the count, so resetting the data would add cost and gain
  // nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//   Issue-side front end of the single-cycle integer ALU. Tagged requests from
//   the reservation station are queued in order in fifo_sync. The FIFO head
//   drives the ALU combinationally. When the result register is free, or is
//   being drained in the same cycle, the ALU result and the head tag are
//   captured, and the head is popped. The captured result is offered to the
//   CDB arbiter over a valid/ready handshake. flush drops every queued request
//   and the pending result.
//
// Ports
//   clk                    in  : clock, rising edge
//   rst                    in  : synchronous active-high reset
//   req_valid / req_ready  in/out : request handshake. req_ready = !full.
//   req_op, req_op1, req_op2, req_robid in : request payload
//   alu_op, alu_op1, alu_op2 out : FIFO head to the ALU. All zero when empty.
//   alu_result             in  : combinational ALU result for the head
//   res_valid / res_ready  out/in : result handshake to the CDB arbiter
//   res_value, res_robid   out : registered result and its ROB tag
//   flush                  in  : discard all in-flight work
//   stall_cnt              out : saturating count of res_valid & !res_ready
//                                cycles. Not cleared by flush.
// -----------------------------------------------------------------------------
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROBW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  // request side
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [31:0]     req_op1,
  input  logic [31:0]     req_op2,
  input  logic [ROBW-1:0] req_robid,
  // ALU side
  output logic [4:0]      alu_op,
  output logic [31:0]     alu_op1,
  output logic [31:0]     alu_op2,
  input  logic [31:0]     alu_result,
  // result side
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_value,
  output logic [ROBW-1:0] res_robid,
  // control / status
  input  logic            flush,
  output logic [15:0]     stall_cnt
);

  localparam int ENTRY_W = CMD_W + ROBW;

  alu_cmd_t            req_cmd;
  alu_cmd_t            head_cmd;
  logic [ROBW-1:0]     head_robid;
  logic [ENTRY_W-1:0]  fifo_din;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_full, fifo_empty;
  logic                push, fire;

  logic                res_valid_q, res_valid_d;
  logic [31:0]         res_value_q, res_value_d;
  logic [ROBW-1:0]     res_robid_q, res_robid_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  assign req_cmd  = '{op: req_op, op1: req_op1, op2: req_op2};
  assign fifo_din = {req_cmd, req_robid};

  // req_ready depends only on registered state. A pop in the same cycle does
  // not reopen a full FIFO; that would need a combinational path from res_ready.
  assign req_ready = ~fifo_full;

  // A request that arrives with flush belongs to the squashed stream.
  assign push = req_valid & req_ready & ~flush;

  // Issue when there is work and the result register is free or draining now.
  assign fire = ~fifo_empty & (~res_valid_q | res_ready) & ~flush;

  fifo_sync #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (fire),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_cmd   = fifo_head[ENTRY_W-1 -: CMD_W];
  assign head_robid = fifo_head[ROBW-1:0];

  // ---------------------------------------------------------------------------
  // ALU drive: zeros while empty. The ALU then computes ADD 0+0 instead of
  // switching on stale entry contents.
  // ---------------------------------------------------------------------------
  assign alu_op  = fifo_empty ? '0 : head_cmd.op;
  assign alu_op1 = fifo_empty ? '0 : head_cmd.op1;
  assign alu_op2 = fifo_empty ? '0 : head_cmd.op2;

  // ---------------------------------------------------------------------------
  // Result register and stall counter
  // ---------------------------------------------------------------------------
  always_comb begin
    res_valid_d = res_valid_q;
    res_value_d = res_value_q;
    res_robid_d = res_robid_q;
    if (flush) begin
      // A result taken by the arbiter in this cycle still counts as delivered.
      // Clearing valid only stops it from being offered again.
      res_valid_d = 1'b0;
    end else if (fire) begin
      // Covers both an empty register and a drain-and-reload in the same cycle.
      res_valid_d = 1'b1;
      res_value_d = alu_result;
      res_robid_d = head_robid;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (res_valid_q && !res_ready) stall_cnt_d = sat_inc16(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_value_q <= '0;
      res_robid_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_value_q <= res_value_d;
      res_robid_q <= res_robid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_value = res_value_q;
  assign res_robid = res_robid_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
//   Directed bench for alu_issue with DEPTH = 4 and ROBW = 6. A behavioural
//   single-cycle ALU sits between the alu_* outputs and alu_result. Inputs
//   change on the falling edge, and outputs are sampled on the falling edge
//   before any new drive.
// -----------------------------------------------------------------------------
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int ROBW  = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [4:0]      req_op = '0;
  logic [31:0]     req_op1 = '0;
  logic [31:0]     req_op2 = '0;
  logic [ROBW-1:0] req_robid = '0;
  logic [4:0]      alu_op;
  logic [31:0]     alu_op1, alu_op2;
  logic [31:0]     alu_result;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [31:0]     res_value;
  logic [ROBW-1:0] res_robid;
  logic            flush = 1'b0;
  logic [15:0]     stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(DEPTH), .ROBW(ROBW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_robid  (req_robid),
    .alu_op     (alu_op),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_value  (res_value),
    .res_robid  (res_robid),
    .flush      (flush),
    .stall_cnt  (stall_cnt)
  );

  // Behavioural single-cycle ALU. PFIND returns 1 + the index of the lowest set
  // bit of op1 & op2, or 0 when no bit is set.
  always_comb begin
    logic [31:0] m;
    alu_result = '0;
    m = alu_op1 & alu_op2;
    case (alu_op)
      OP_ADD:  alu_result = alu_op1 + alu_op2;
      OP_SUB:  alu_result = alu_op1 - alu_op2;
      OP_SLL:  alu_result = alu_op1 << alu_op2[4:0];
      OP_SLT:  alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
      OP_SLTU: alu_result = {31'd0, alu_op1 < alu_op2};
      OP_XOR:  alu_result = alu_op1 ^ alu_op2;
      OP_SEQ:  alu_result = {31'd0, alu_op1 == alu_op2};
      OP_SRL:  alu_result = alu_op1 >> alu_op2[4:0];
      OP_SRA:  alu_result = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
      OP_OR:   alu_result = alu_op1 | alu_op2;
      OP_AND:  alu_result = alu_op1 & alu_op2;
      OP_PFIND: begin
        for (int b = 31; b >= 0; b--) if (m[b]) alu_result = 32'(b + 1);
      end
      OP_PCLR: alu_result = alu_op1 & ~alu_op2;
      default: alu_result = '0;
    endcase
  end

  task automatic drive_req(input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [ROBW-1:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_op1   = a;
    req_op2   = b;
    req_robid = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1)  begin errors++; $display("FAIL reset.req_ready got=%b exp=1", req_ready); end
    checks++; if (res_valid !== 1'b0)  begin errors++; $display("FAIL reset.res_valid got=%b exp=0", res_valid); end
    checks++; if (res_value !== 32'd0) begin errors++; $display("FAIL reset.res_value got=%h exp=0", res_value); end
    checks++; if (res_robid !== '0)    begin errors++; $display("FAIL reset.res_robid got=%h exp=0", res_robid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset.stall_cnt got=%h exp=0", stall_cnt); end
    checks++; if ({alu_op, alu_op1, alu_op2} !== '0) begin errors++; $display("FAIL reset.alu got=%h/%h/%h exp=0", alu_op, alu_op1, alu_op2); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    @(negedge clk);
    res_ready = 1'b1;
    drive_req(OP_ADD, 32'd5, 32'd7, 6'd3);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin errors++; $display("FAIL add.alu_drive got=%0d,%0d exp=5,7", alu_op1, alu_op2); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add.no_bypass got=%b exp=0", res_valid); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL add.res_valid got=%b exp=1", res_valid); end
    checks++; if (res_value !== 32'd12) begin errors++; $display("FAIL add.res_value got=%0d exp=12", res_value); end
    checks++; if (res_robid !== 6'd3) begin errors++; $display("FAIL add.res_robid got=%0d exp=3", res_robid); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add.drained got=%b exp=0", res_valid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]      ops [3];
    logic [31:0]     a   [3];
    logic [31:0]     b   [3];
    logic [31:0]     ev  [3];
    int k;
    ops[0] = OP_SUB;   a[0] = 32'd10;   b[0] = 32'd3;    ev[0] = 32'd7;
    ops[1] = OP_SLL;   a[1] = 32'd1;    b[1] = 32'd4;    ev[1] = 32'd16;
    ops[2] = OP_PFIND; a[2] = 32'hF0;   b[2] = 32'h10;   ev[2] = 32'h5;
    res_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (res_valid) begin
        checks++;
        if (k >= 3) begin
          errors++; $display("FAIL b2b.extra got tag=%0d exp=none", res_robid);
        end else if (res_value !== ev[k] || res_robid !== 6'(k + 1)) begin
          errors++; $display("FAIL b2b.result%0d got=%h/%0d exp=%h/%0d", k, res_value, res_robid, ev[k], k + 1);
        end
        k++;
      end
      // Consecutive results: the third result lands on iteration 4.
      if (i == 3) begin
        checks++; if (res_valid !== 1'b1 || k != 2) begin errors++; $display("FAIL b2b.throughput got valid=%b count=%0d exp=1/2", res_valid, k); end
      end
      if (i < 3) drive_req(ops[i], a[i], b[i], 6'(i + 1));
      else req_valid = 1'b0;
    end
    checks++; if (k != 3) begin errors++; $display("FAIL b2b.count got=%0d exp=3", k); end
  endtask

  task automatic test_backpressure();
    int accepted;
    int k;
    logic [15:0] s0;
    res_ready = 1'b0;
    @(negedge clk);
    drive_req(OP_ADD, 32'd1, 32'd1, 6'd20);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_value !== 32'd2) begin errors++; $display("FAIL bp.first got=%b/%0d exp=1/2", res_valid, res_value); end
    accepted = 0;
    s0 = stall_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clk);
      if (req_ready) accepted++;
      drive_req(OP_ADD, 32'(i * 16), 32'd3, 6'(20 + i));
    end
    @(negedge clk);
    checks++; if (accepted != 4) begin errors++; $display("FAIL bp.accepted got=%0d exp=4", accepted); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp.full got=%b exp=0", req_ready); end
    checks++; if (res_value !== 32'd2 || res_robid !== 6'd20) begin errors++; $display("FAIL bp.hold got=%0d/%0d exp=2/20", res_value, res_robid); end
    checks++; if (stall_cnt !== s0 + 16'd5) begin errors++; $display("FAIL bp.stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 16'd5); end
    req_valid = 1'b0;
    res_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp.reopen got=%b exp=1", req_ready); end
      end
      if (res_valid) begin
        checks++;
        if (k >= 4) begin
          errors++; $display("FAIL bp.extra got tag=%0d exp=none", res_robid);
        end else if (res_value !== 32'((k + 1) * 16 + 3) || res_robid !== 6'(21 + k)) begin
          errors++; $display("FAIL bp.drain%0d got=%0d/%0d exp=%0d/%0d", k, res_value, res_robid, (k + 1) * 16 + 3, 21 + k);
        end
        k++;
      end
    end
    checks++; if (k != 4) begin errors++; $display("FAIL bp.drain_count got=%0d exp=4", k); end
  endtask

  task automatic test_flush();
    logic [15:0] s;
    int seen;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_req(OP_SUB, 32'd9, 32'(i), 6'(30 + i));
    end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_robid !== 6'd30) begin errors++; $display("FAIL flush.pre got=%b/%0d exp=1/30", res_valid, res_robid); end
    s = stall_cnt;
    drive_req(OP_SUB, 32'd9, 32'd4, 6'd34);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush.res_valid got=%b exp=0", res_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush.req_ready got=%b exp=1", req_ready); end
    checks++; if ({alu_op, alu_op1, alu_op2} !== '0) begin errors++; $display("FAIL flush.empty got=%h/%h/%h exp=0", alu_op, alu_op1, alu_op2); end
    checks++; if (stall_cnt !== s + 16'd1) begin errors++; $display("FAIL flush.stall_kept got=%0d exp=%0d", stall_cnt, s + 16'd1); end
    res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush.ghost got=%0d results exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    @(negedge clk); drive_req(OP_XOR, 32'hFF, 32'h0F, 6'd40);
    @(negedge clk); drive_req(OP_OR,  32'h01, 32'h02, 6'd41);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || stall_cnt == 16'd0) begin errors++; $display("FAIL rstmid.pre got=%b/%0d exp=1/>0", res_valid, stall_cnt); end
    rst = 1'b1;
    drive_req(OP_ADD, 32'd1, 32'd2, 6'd42);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rstmid.hs got=%b/%b exp=1/0", req_ready, res_valid); end
    checks++; if (res_value !== 32'd0 || res_robid !== '0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL rstmid.regs got=%h/%0d/%0d exp=0/0/0", res_value, res_robid, stall_cnt); end
    checks++; if ({alu_op, alu_op1, alu_op2} !== '0) begin errors++; $display("FAIL rstmid.alu got=%h/%h/%h exp=0", alu_op, alu_op1, alu_op2); end
    res_ready = 1'b1;
    drive_req(OP_SRA, 32'h8000_0000, 32'd4, 6'd7);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_value !== 32'hF800_0000 || res_robid !== 6'd7) begin errors++; $display("FAIL rstmid.sra got=%b/%h/%0d exp=1/f8000000/7", res_valid, res_value, res_robid); end
    @(negedge clk);
  endtask

  task automatic test_stall_sat();
    res_ready = 1'b0;
    drive_req(OP_ADD, 32'd0, 32'd0, 6'd9);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || stall_cnt !== 16'd0) begin errors++; $display("FAIL sat.start got=%b/%0d exp=1/0", res_valid, stall_cnt); end
    repeat (100) @(negedge clk);
    checks++; if (stall_cnt !== 16'd100) begin errors++; $display("FAIL sat.count100 got=%0d exp=100", stall_cnt); end
    repeat (70000) @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat.saturated got=%h exp=ffff", stall_cnt); end
    repeat (5) @(negedge clk);
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat.sticky got=%h exp=ffff", stall_cnt); end
    res_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_stall_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
